// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: each accepted beat is steered by s into one
// of two independent FIFOs, each with its own valid/ready handshake and delivery counter.
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           d,
  input  logic                       s,
  input  logic                       d_valid,
  output logic                       d_ready,
  output logic [WIDTH-1:0]           y0,
  output logic [WIDTH-1:0]           y1,
  output logic                       y0_valid,
  output logic                       y1_valid,
  input  logic                       y0_ready,
  input  logic                       y1_ready,
  output logic [$clog2(DEPTH):0]     lvl0,
  output logic [$clog2(DEPTH):0]     lvl1,
  output logic [7:0]                 cnt0,
  output logic [7:0]                 cnt1
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]    wptr [2];
  logic [PW-1:0]    rptr [2];
  logic [LW-1:0]    lvl  [2];
  logic [7:0]       cnt  [2];
  logic [WIDTH-1:0] mem  [2][DEPTH];

  logic [1:0] full, empty, push, pop, out_ready;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < 2; c++) begin
      full[c]  = (lvl[c] == LW'(DEPTH));
      empty[c] = (lvl[c] == '0);
    end
  end

  // Readiness looks only at the channel s points to, so a stalled peer never blocks.
  assign d_ready   = rst_n && (s ? !full[1] : !full[0]);
  assign push[0]   = d_valid && d_ready && !s;
  assign push[1]   = d_valid && d_ready &&  s;
  assign out_ready = {y1_ready, y0_ready};
  assign pop       = out_ready & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        lvl[c]  <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + PW'(1);
        if (pop[c]) begin
          rptr[c] <= rptr[c] + PW'(1);
          cnt[c]  <= cnt[c] + 8'd1;
        end
        case ({push[c], pop[c]})
          2'b10:   lvl[c] <= lvl[c] + LW'(1);
          2'b01:   lvl[c] <= lvl[c] - LW'(1);
          default: lvl[c] <= lvl[c];
        endcase
      end
    end
  end

  // Storage carries no reset; empty-gating on the outputs hides stale entries.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++)
      if (push[c]) mem[c][wptr[c]] <= d;
  end

  assign y0       = empty[0] ? '0 : mem[0][rptr[0]];
  assign y1       = empty[1] ? '0 : mem[1][rptr[1]];
  assign y0_valid = !empty[0];
  assign y1_valid = !empty[1];
  assign lvl0     = lvl[0];
  assign lvl1     = lvl[1];
  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Directed and randomized bench for demux2_stream with per-channel reference queues.
module tb_demux2_stream;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] d;
  logic             s;
  logic             d_valid;
  logic             d_ready;
  logic [WIDTH-1:0] y0, y1;
  logic             y0_valid, y1_valid;
  logic             y0_ready, y1_ready;
  logic [LW-1:0]    lvl0, lvl1;
  logic [7:0]       cnt0, cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  demux2_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .d_valid(d_valid), .d_ready(d_ready),
    .y0(y0), .y1(y1), .y0_valid(y0_valid), .y1_valid(y1_valid),
    .y0_ready(y0_ready), .y1_ready(y1_ready),
    .lvl0(lvl0), .lvl1(lvl1), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q0[$], q1[$];
  logic             acc, p0, p1;
  logic [WIDTH-1:0] exp0, exp1;

  initial begin
    rst_n = 1'b0; d = '0; s = 1'b0; d_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
    step(); step();
    #3 rst_n = 1'b1;
    step();
    chk("release_lvl0", lvl0, 0);
    chk("release_lvl1", lvl1, 0);
    chk("release_dready", d_ready, 1);

    // Routing
    y0_ready = 1'b1; y1_ready = 1'b1;
    d = 8'h11; s = 1'b0; d_valid = 1'b1;
    #1 chk("route_y0_not_yet", y0_valid, 0);
    step();
    chk("route_y0_valid", y0_valid, 1);
    chk("route_y0_data", y0, 8'h11);
    d = 8'h22; s = 1'b1;
    step();
    chk("route_y1_valid", y1_valid, 1);
    chk("route_y1_data", y1, 8'h22);
    chk("route_y0_drained", y0_valid, 0);
    chk("route_cnt0", cnt0, 1);
    d_valid = 1'b0;
    step();
    chk("route_cnt1", cnt1, 1);
    chk("route_y1_empty_zero", y1, 0);

    // Full and back-pressure
    y0_ready = 1'b0; y1_ready = 1'b0;
    d_valid = 1'b1; s = 1'b0; d = 8'hA0;
    step();
    d = 8'hA1;
    step();
    chk("full_lvl0", lvl0, 2);
    d = 8'hA2;
    #1 chk("full_dready_s0", d_ready, 0);
    s = 1'b1; d = 8'hB0;
    #1 chk("full_dready_s1", d_ready, 1);
    step();
    chk("full_lvl1", lvl1, 1);
    chk("full_y1", y1, 8'hB0);
    chk("full_lvl0_hold", lvl0, 2);
    chk("full_y0_head", y0, 8'hA0);
    d_valid = 1'b0; y0_ready = 1'b1;
    step();
    chk("drain_y0_a1", y0, 8'hA1);
    chk("drain_lvl0", lvl0, 1);
    s = 1'b0;
    #1 chk("drain_dready", d_ready, 1);
    step();
    chk("drain_lvl0_empty", lvl0, 0);
    chk("drain_cnt0", cnt0, 3);
    y1_ready = 1'b1;
    step();
    chk("drain_cnt1", cnt1, 2);

    // Simultaneous push and pop across pointer wrap
    y0_ready = 1'b0; s = 1'b0; d_valid = 1'b1; d = 8'hC0;
    step();
    chk("sim_lvl0_start", lvl0, 1);
    y0_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 8'hC1 + 8'(i);
      step();
      chk("sim_lvl0", lvl0, 1);
      chk("sim_y0", y0, 8'hC1 + 8'(i));
    end
    d_valid = 1'b0;
    step();
    chk("sim_lvl0_end", lvl0, 0);
    chk("sim_cnt0", cnt0, 14);

    // Reset mid-stream with one beat in each FIFO
    y0_ready = 1'b0; y1_ready = 1'b0; d_valid = 1'b1; s = 1'b0; d = 8'hE0;
    step();
    s = 1'b1; d = 8'hE1;
    step();
    d_valid = 1'b0;
    chk("pre_rst_lvl0", lvl0, 1);
    chk("pre_rst_lvl1", lvl1, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_y0", y0, 0);
    chk("rst_y1", y1, 0);
    chk("rst_y0_valid", y0_valid, 0);
    chk("rst_y1_valid", y1_valid, 0);
    chk("rst_lvl0", lvl0, 0);
    chk("rst_lvl1", lvl1, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_dready", d_ready, 0);
    step();
    #3 rst_n = 1'b1;
    step();
    chk("rel_lvl0", lvl0, 0);
    chk("rel_lvl1", lvl1, 0);
    chk("rel_dready_s1", d_ready, 1);

    // Counter wrap on channel 1
    y1_ready = 1'b1; s = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      d = 8'(i);
      step();
      if (i == 100) chk("wrap_y1_order", y1, 8'd100);
    end
    chk("wrap_cnt1_256", cnt1, 0);
    d_valid = 1'b0;
    step();
    chk("wrap_cnt1", cnt1, 1);
    chk("wrap_cnt0", cnt0, 0);

    // Random soak against per-channel scoreboards
    d_valid = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!(d_valid && !d_ready)) begin
        d_valid = 1'($urandom_range(0, 1));
        s       = 1'($urandom_range(0, 1));
        d       = 8'($urandom_range(0, 255));
      end
      y0_ready = 1'($urandom_range(0, 1));
      y1_ready = 1'($urandom_range(0, 1));
      #1;
      acc = d_valid && d_ready;
      p0  = y0_valid && y0_ready;
      p1  = y1_valid && y1_ready;
      exp0 = (q0.size() > 0) ? q0[0] : '0;
      exp1 = (q1.size() > 0) ? q1[0] : '0;
      chk("soak_y0", {y0_valid, lvl0, y0}, {q0.size() > 0, LW'(q0.size()), exp0});
      chk("soak_y1", {y1_valid, lvl1, y1}, {q1.size() > 0, LW'(q1.size()), exp1});
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc && !s) q0.push_back(d);
      if (acc &&  s) q1.push_back(d);
      step();
      if (lvl0 > LW'(DEPTH) || lvl1 > LW'(DEPTH)) chk("soak_lvl_bound", {lvl0, lvl1}, {LW'(DEPTH), LW'(DEPTH)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
